stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Control sequencer for the stopwatch time-counter datapath. It turns debounced single-cycle button pulses (start/stop, lap, clear, recall) into the datapath count enable and clear. It also stores up to `LAP_DEPTH` lap times and selects the 16-bit BCD value (M, S-tens, S-units, tenths) that the display multiplexer shows. It sits between the debouncers and the counter/`time_multiplexer` pair.

## Interface
- `LAP_DEPTH`, default 8: number of stored lap entries.
- `SPLIT_HOLD`, default 200000000: number of clk_i cycles the split display is held (2 s at 100 MHz).
- `STOP_ON_WRAP`, default 1: when 1, counter wrap forces PAUSE; when 0, the counter runs through the wrap.
- `clk_i` in 1: single clock; all state changes on the rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `start_stop_i` in 1: debounced start/stop pulse, 1 cycle.
- `lap_i` in 1: debounced lap pulse, 1 cycle.
- `clear_i` in 1: debounced clear pulse, 1 cycle.
- `recall_i` in 1: debounced lap-review pulse, 1 cycle.
- `time_i` in 16: live BCD time from the datapath, {min, sec_tens, sec_units, tenths}.
- `wrap_i` in 1: 1-cycle pulse from the datapath on rollover 9:59.9 -> 0:00.0.
- `run_o` out 1: datapath count enable.
- `clear_o` out 1: 1-cycle datapath synchronous clear.
- `disp_o` out 16: BCD value to the display mux.
- `state_o` out 3: current state (IDLE=0, RUN=1, SPLIT=2, PAUSE=3, REVIEW=4).
- `lap_count_o` out $clog2(LAP_DEPTH+1): number of stored laps.
- `lap_full_o` out 1: high when lap_count_o == LAP_DEPTH.

## Operation
- Priority when pulses coincide in one cycle: clear_i > start_stop_i > lap_i > recall_i. Only the highest-priority pulse is acted on; the others are dropped.
- **IDLE**
  - run_o=0.
  - start_stop -> RUN.
  - clear -> clear_o pulse and lap_count=0; state stays IDLE.
  - recall with lap_count>0 -> REVIEW, index=0, return state = IDLE.
- **RUN**
  - run_o=1.
  - start_stop -> PAUSE.
  - lap -> capture time_i into the held register. If not full, also write time_i to lap_mem[lap_count] and increment lap_count. Load the hold counter with SPLIT_HOLD-1. -> SPLIT.
  - clear and recall are ignored.
- **SPLIT**
  - run_o=1; disp_o = held value.
  - Hold counter decrements each cycle; at 0 -> RUN.
  - lap -> recapture and store as in RUN, and reload the hold counter.
  - start_stop -> PAUSE.
  - clear and recall are ignored.
- **PAUSE**
  - run_o=0.
  - start_stop -> RUN.
  - clear -> clear_o pulse, lap_count=0 -> IDLE.
  - recall with lap_count>0 -> REVIEW, index=0, return state = PAUSE.
  - lap is ignored.
- **REVIEW**
  - run_o=0; disp_o = lap_mem[index].
  - recall -> index+1, wrapping to 0 when index+1 == lap_count.
  - start_stop -> return state.
  - clear -> clear_o pulse, lap_count=0 -> IDLE.
  - lap is ignored.
- **wrap_i** in RUN or SPLIT with STOP_ON_WRAP=1 -> PAUSE; run_o drops the next cycle. wrap_i has lower priority than clear_i and start_stop_i, and higher priority than lap_i.
- **Lap memory when full:** lap_i still refreshes the split display but performs no write, and lap_count saturates at LAP_DEPTH.
- **Display selection:** disp_o = time_i (combinational passthrough) in IDLE, RUN and PAUSE.
- **Lap memory storage:** plain registers, not reset. Contents beyond lap_count are don't-care. Clear only zeroes lap_count.

## Timing
- **Reset values:** state IDLE, run_o=0, clear_o=0, lap_count_o=0, lap_full_o=0, state_o=0, hold counter=0, index=0. disp_o = time_i.
- **Registered outputs:** run_o, clear_o, state_o, lap_count_o and lap_full_o are registered. Each changes on the edge that samples the causing pulse, so it is visible 1 cycle after the pulse.
- **clear_o** is high for exactly 1 cycle per accepted clear.
- **Lap capture:** the lap write captures time_i as presented in the same cycle as lap_i. disp_o shows the captured value from the next cycle onward.
- **SPLIT duration:** with no further pulses, SPLIT lasts exactly SPLIT_HOLD cycles, then RUN.
- **REVIEW index:** the index advances 1 cycle after recall_i; disp_o follows combinationally from the index register.
- **Reset mid-operation:** asserting rst_ni low from any state forces all reset values immediately, without a clock edge. No clear_o pulse is emitted.

## Test plan
- **Basic start/stop:** reset, then start_stop -> run_o=1 next cycle, state_o=1. A second start_stop -> run_o=0, state_o=3.
- **Split timing:** SPLIT_HOLD=4. In RUN with time_i=16'h0123, pulse lap -> disp_o=16'h0123 for 4 cycles while time_i changes, then state_o=1, lap_count_o=1.
- **Lap overflow:** LAP_DEPTH=2. Three laps with time_i 0x0011, 0x0022, 0x0033 -> lap_count_o=2, lap_full_o=1, disp_o=0x0033 during the third split. Then pause and recall -> disp_o 0x0011, then 0x0022, then wraps to 0x0011.
- **Clear gating and priority:** clear in RUN is ignored (clear_o stays 0). In PAUSE, clear and start_stop in the same cycle -> clear_o pulses once, state_o=0, lap_count_o=0, run_o=0.
- **Wrap handling:** STOP_ON_WRAP=1, wrap_i in RUN -> state_o=3 next cycle. STOP_ON_WRAP=0 -> stays RUN.
- **Reset mid-operation:** rst_ni low mid-SPLIT -> all outputs at reset values immediately. After release, start_stop -> RUN.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   Control sequencer for the stopwatch time-counter datapath. Turns debounced
//   single-cycle button pulses into the datapath count enable / clear, keeps up
//   to LAP_DEPTH lap times and selects the BCD value shown on the display.
//
// Ports
//   clk_i          single clock, rising edge
//   rst_ni         asynchronous active-low reset
//   start_stop_i   start/stop pulse (1 cycle)
//   lap_i          lap pulse (1 cycle)
//   clear_i        clear pulse (1 cycle)
//   recall_i       lap-review pulse (1 cycle)
//   time_i[15:0]   live BCD time {min, sec_tens, sec_units, tenths}
//   wrap_i         1-cycle pulse on 9:59.9 -> 0:00.0 rollover
//   run_o          datapath count enable (registered)
//   clear_o        1-cycle datapath clear (registered)
//   disp_o[15:0]   BCD value for the display mux (combinational select)
//   state_o[2:0]   IDLE=0 RUN=1 SPLIT=2 PAUSE=3 REVIEW=4 (registered)
//   lap_count_o    number of stored laps (registered)
//   lap_full_o     lap_count_o == LAP_DEPTH (registered)
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int LAP_DEPTH    = 8,
  parameter int SPLIT_HOLD   = 200000000,
  parameter bit STOP_ON_WRAP = 1'b1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               start_stop_i,
  input  logic                               lap_i,
  input  logic                               clear_i,
  input  logic                               recall_i,
  input  logic [15:0]                        time_i,
  input  logic                               wrap_i,
  output logic                               run_o,
  output logic                               clear_o,
  output logic [15:0]                        disp_o,
  output logic [2:0]                         state_o,
  output logic [$clog2(LAP_DEPTH+1)-1:0]     lap_count_o,
  output logic                               lap_full_o
);

  localparam int CW = $clog2(LAP_DEPTH + 1);
  localparam int IW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam int HW = (SPLIT_HOLD > 1) ? $clog2(SPLIT_HOLD) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_SPLIT  = 3'd2,
    S_PAUSE  = 3'd3,
    S_REVIEW = 3'd4
  } state_t;

  state_t          r_state, w_state_next;
  state_t          r_ret,   w_ret_next;     // state to return to from REVIEW
  logic            r_run,   w_run_next;
  logic            r_clear, w_clear_next;
  logic [CW-1:0]   r_lap_count, w_lap_count_next;
  logic            r_lap_full;
  logic [HW-1:0]   r_hold,  w_hold_next;
  logic [IW-1:0]   r_idx,   w_idx_next;
  logic [15:0]     r_held,  w_held_next;
  logic            w_do_lap;
  logic            w_mem_we;
  logic            w_full;
  logic [CW-1:0]   w_idx_inc;

  // Lap storage: plain registers, never reset; only lap_count is cleared.
  logic [15:0]     r_lap_mem [LAP_DEPTH];

  assign w_full    = (r_lap_count == CW'(LAP_DEPTH));
  assign w_idx_inc = CW'(r_idx) + CW'(1);

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority: clear > start_stop > wrap > lap > recall.
  // A pulse a state ignores does not mask lower-priority pulses.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next     = r_state;
    w_ret_next       = r_ret;
    w_clear_next     = 1'b0;
    w_lap_count_next = r_lap_count;
    w_hold_next      = r_hold;
    w_idx_next       = r_idx;
    w_held_next      = r_held;
    w_do_lap         = 1'b0;
    w_mem_we         = 1'b0;
    w_run_next       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (clear_i) begin
          w_clear_next     = 1'b1;
          w_lap_count_next = '0;
        end else if (start_stop_i) begin
          w_state_next = S_RUN;
        end else if (recall_i && (r_lap_count != '0)) begin
          w_state_next = S_REVIEW;
          w_idx_next   = '0;
          w_ret_next   = S_IDLE;
        end
      end
      S_RUN: begin
        if (start_stop_i) begin
          w_state_next = S_PAUSE;
        end else if (STOP_ON_WRAP && wrap_i) begin
          w_state_next = S_PAUSE;
        end else if (lap_i) begin
          w_do_lap = 1'b1;
        end
      end
      S_SPLIT: begin
        if (start_stop_i) begin
          w_state_next = S_PAUSE;
        end else if (STOP_ON_WRAP && wrap_i) begin
          w_state_next = S_PAUSE;
        end else if (lap_i) begin
          w_do_lap = 1'b1;
        end else if (r_hold == '0) begin
          w_state_next = S_RUN;
        end else begin
          w_hold_next = r_hold - 1'b1;
        end
      end
      S_PAUSE: begin
        if (clear_i) begin
          w_clear_next     = 1'b1;
          w_lap_count_next = '0;
          w_state_next     = S_IDLE;
        end else if (start_stop_i) begin
          w_state_next = S_RUN;
        end else if (recall_i && (r_lap_count != '0)) begin
          w_state_next = S_REVIEW;
          w_idx_next   = '0;
          w_ret_next   = S_PAUSE;
        end
      end
      S_REVIEW: begin
        if (clear_i) begin
          w_clear_next     = 1'b1;
          w_lap_count_next = '0;
          w_state_next     = S_IDLE;
        end else if (start_stop_i) begin
          w_state_next = r_ret;
        end else if (recall_i) begin
          w_idx_next = (w_idx_inc == r_lap_count) ? '0 : w_idx_inc[IW-1:0];
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Lap capture shared by RUN and SPLIT: the split display always refreshes,
    // the memory write only happens while there is room.
    if (w_do_lap) begin
      w_state_next = S_SPLIT;
      w_held_next  = time_i;
      w_hold_next  = HW'(SPLIT_HOLD - 1);
      if (!w_full) begin
        w_mem_we         = 1'b1;
        w_lap_count_next = r_lap_count + 1'b1;
      end
    end

    // run_o is registered from the next state so it tracks state_o exactly.
    w_run_next = (w_state_next == S_RUN) || (w_state_next == S_SPLIT);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_ret       <= S_IDLE;
      r_run       <= 1'b0;
      r_clear     <= 1'b0;
      r_lap_count <= '0;
      r_lap_full  <= 1'b0;
      r_hold      <= '0;
      r_idx       <= '0;
      r_held      <= '0;
    end else begin
      r_state     <= w_state_next;
      r_ret       <= w_ret_next;
      r_run       <= w_run_next;
      r_clear     <= w_clear_next;
      r_lap_count <= w_lap_count_next;
      r_lap_full  <= (w_lap_count_next == CW'(LAP_DEPTH));
      r_hold      <= w_hold_next;
      r_idx       <= w_idx_next;
      r_held      <= w_held_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      r_lap_mem[r_lap_count[IW-1:0]] <= time_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    disp_o = time_i;
    case (r_state)
      S_SPLIT:  disp_o = r_held;
      S_REVIEW: disp_o = r_lap_mem[r_idx];
      default:  disp_o = time_i;
    endcase
  end

  assign run_o       = r_run;
  assign clear_o     = r_clear;
  assign state_o     = r_state;
  assign lap_count_o = r_lap_count;
  assign lap_full_o  = r_lap_full;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//   Directed bench for stopwatch_ctrl. dut1: LAP_DEPTH=2, SPLIT_HOLD=4,
//   STOP_ON_WRAP=1. dut2: same but STOP_ON_WRAP=0, driven by the same inputs.
//   Inputs change 1 time unit after the rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        ss, lap, clr, rec, wrap;
  logic [15:0] time_v;

  logic        run1, clro1, full1;
  logic [15:0] disp1;
  logic [2:0]  st1;
  logic [1:0]  cnt1;
  logic        run2, clro2, full2;
  logic [15:0] disp2;
  logic [2:0]  st2;
  logic [1:0]  cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.LAP_DEPTH(2), .SPLIT_HOLD(4), .STOP_ON_WRAP(1'b1)) dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .start_stop_i(ss), .lap_i(lap),
    .clear_i(clr), .recall_i(rec), .time_i(time_v), .wrap_i(wrap),
    .run_o(run1), .clear_o(clro1), .disp_o(disp1), .state_o(st1),
    .lap_count_o(cnt1), .lap_full_o(full1)
  );

  stopwatch_ctrl #(.LAP_DEPTH(2), .SPLIT_HOLD(4), .STOP_ON_WRAP(1'b0)) dut2 (
    .clk_i(clk), .rst_ni(rst_ni), .start_stop_i(ss), .lap_i(lap),
    .clear_i(clr), .recall_i(rec), .time_i(time_v), .wrap_i(wrap),
    .run_o(run2), .clear_o(clro2), .disp_o(disp2), .state_o(st2),
    .lap_count_o(cnt2), .lap_full_o(full2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pulse on any combination of inputs: {ss, lap, clr, rec, wrap}.
  task automatic pulse(input logic p_ss, input logic p_lap, input logic p_clr,
                       input logic p_rec, input logic p_wrap);
    {ss, lap, clr, rec, wrap} = {p_ss, p_lap, p_clr, p_rec, p_wrap};
    tick();
    {ss, lap, clr, rec, wrap} = 5'b0;
  endtask

  // Flags below are packed as {run, clear, state[2:0], count[1:0], full}.
  task automatic test_reset();
    rst_ni = 1'b0;
    {ss, lap, clr, rec, wrap} = 5'b0;
    time_v = 16'h1234;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({run1, clro1, st1, cnt1, full1} !== {1'b0, 1'b0, 3'd0, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL reset_flags got=%h exp=%h", {run1, clro1, st1, cnt1, full1}, 8'h00);
    end
    total++;
    if (disp1 !== 16'h1234) begin
      bad++;
      $display("FAIL reset_disp got=%h exp=%h", disp1, 16'h1234);
    end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_start_stop();
    pulse(1, 0, 0, 0, 0);
    total++;
    if ({run1, clro1, st1, cnt1, full1} !== {1'b1, 1'b0, 3'd1, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL start_run got=%h exp=%h", {run1, clro1, st1, cnt1, full1},
               {1'b1, 1'b0, 3'd1, 2'd0, 1'b0});
    end
    total++;
    if (disp1 !== 16'h1234) begin
      bad++;
      $display("FAIL run_passthrough got=%h exp=%h", disp1, 16'h1234);
    end
    pulse(1, 0, 0, 0, 0);
    total++;
    if ({run1, clro1, st1, cnt1, full1} !== {1'b0, 1'b0, 3'd3, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL stop_pause got=%h exp=%h", {run1, clro1, st1, cnt1, full1},
               {1'b0, 1'b0, 3'd3, 2'd0, 1'b0});
    end
    pulse(0, 0, 1, 0, 0);
    total++;
    if ({run1, clro1, st1, cnt1, full1} !== {1'b0, 1'b1, 3'd0, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL pause_clear got=%h exp=%h", {run1, clro1, st1, cnt1, full1},
               {1'b0, 1'b1, 3'd0, 2'd0, 1'b0});
    end
    tick();
    total++;
    if (clro1 !== 1'b0) begin
      bad++;
      $display("FAIL clear_one_cycle got=%b exp=0", clro1);
    end
  endtask

  task automatic test_split_timing();
    pulse(1, 0, 0, 0, 0);
    time_v = 16'h0123;
    pulse(0, 1, 0, 0, 0);
    time_v = 16'h0456;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({st1, run1, cnt1, disp1} !== {3'd2, 1'b1, 2'd1, 16'h0123}) begin
        bad++;
        $display("FAIL split_hold_%0d got st=%0d run=%b cnt=%0d disp=%h exp st=2 run=1 cnt=1 disp=0123",
                 i, st1, run1, cnt1, disp1);
      end
      tick();
    end
    total++;
    if ({st1, run1, cnt1, full1, disp1} !== {3'd1, 1'b1, 2'd1, 1'b0, 16'h0456}) begin
      bad++;
      $display("FAIL split_end got st=%0d run=%b cnt=%0d full=%b disp=%h exp st=1 run=1 cnt=1 full=0 disp=0456",
               st1, run1, cnt1, full1, disp1);
    end
  endtask

  task automatic test_lap_overflow();
    pulse(1, 0, 0, 0, 0);   // RUN -> PAUSE
    pulse(0, 0, 1, 0, 0);   // PAUSE -> IDLE, count 0
    total++;
    if ({clro1, st1, cnt1} !== {1'b1, 3'd0, 2'd0}) begin
      bad++;
      $display("FAIL ovf_clear got clr=%b st=%0d cnt=%0d exp clr=1 st=0 cnt=0", clro1, st1, cnt1);
    end
    pulse(1, 0, 0, 0, 0);   // RUN
    time_v = 16'h0011;
    pulse(0, 1, 0, 0, 0);
    total++;
    if ({st1, cnt1, full1} !== {3'd2, 2'd1, 1'b0}) begin
      bad++;
      $display("FAIL ovf_lap1 got st=%0d cnt=%0d full=%b exp st=2 cnt=1 full=0", st1, cnt1, full1);
    end
    time_v = 16'h0022;
    pulse(0, 1, 0, 0, 0);
    total++;
    if ({st1, cnt1, full1, disp1} !== {3'd2, 2'd2, 1'b1, 16'h0022}) begin
      bad++;
      $display("FAIL ovf_lap2 got st=%0d cnt=%0d full=%b disp=%h exp st=2 cnt=2 full=1 disp=0022",
               st1, cnt1, full1, disp1);
    end
    time_v = 16'h0033;
    pulse(0, 1, 0, 0, 0);
    time_v = 16'h0999;
    total++;
    if ({st1, cnt1, full1, disp1} !== {3'd2, 2'd2, 1'b1, 16'h0033}) begin
      bad++;
      $display("FAIL ovf_lap3 got st=%0d cnt=%0d full=%b disp=%h exp st=2 cnt=2 full=1 disp=0033",
               st1, cnt1, full1, disp1);
    end
    pulse(1, 0, 0, 0, 0);   // SPLIT -> PAUSE
    total++;
    if ({run1, st1, disp1} !== {1'b0, 3'd3, 16'h0999}) begin
      bad++;
      $display("FAIL ovf_pause got run=%b st=%0d disp=%h exp run=0 st=3 disp=0999", run1, st1, disp1);
    end
    pulse(0, 0, 0, 1, 0);
    total++;
    if ({st1, disp1} !== {3'd4, 16'h0011}) begin
      bad++;
      $display("FAIL review_0 got st=%0d disp=%h exp st=4 disp=0011", st1, disp1);
    end
    pulse(0, 0, 0, 1, 0);
    total++;
    if ({st1, disp1} !== {3'd4, 16'h0022}) begin
      bad++;
      $display("FAIL review_1 got st=%0d disp=%h exp st=4 disp=0022", st1, disp1);
    end
    pulse(0, 0, 0, 1, 0);
    total++;
    if ({st1, disp1} !== {3'd4, 16'h0011}) begin
      bad++;
      $display("FAIL review_wrap got st=%0d disp=%h exp st=4 disp=0011", st1, disp1);
    end
    pulse(1, 0, 0, 0, 0);   // back to PAUSE
    total++;
    if ({run1, st1, disp1} !== {1'b0, 3'd3, 16'h0999}) begin
      bad++;
      $display("FAIL review_return got run=%b st=%0d disp=%h exp run=0 st=3 disp=0999", run1, st1, disp1);
    end
  endtask

  task automatic test_clear_priority();
    pulse(1, 0, 0, 0, 0);   // PAUSE -> RUN
    pulse(0, 0, 1, 0, 0);   // ignored in RUN
    total++;
    if ({clro1, st1, cnt1, run1} !== {1'b0, 3'd1, 2'd2, 1'b1}) begin
      bad++;
      $display("FAIL run_clear_ignored got clr=%b st=%0d cnt=%0d run=%b exp clr=0 st=1 cnt=2 run=1",
               clro1, st1, cnt1, run1);
    end
    pulse(1, 0, 0, 0, 0);   // RUN -> PAUSE
    pulse(1, 0, 1, 0, 0);   // clear wins over start_stop
    total++;
    if ({run1, clro1, st1, cnt1, full1} !== {1'b0, 1'b1, 3'd0, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL clear_priority got=%h exp=%h", {run1, clro1, st1, cnt1, full1},
               {1'b0, 1'b1, 3'd0, 2'd0, 1'b0});
    end
    tick();
    total++;
    if ({clro1, st1} !== {1'b0, 3'd0}) begin
      bad++;
      $display("FAIL clear_single got clr=%b st=%0d exp clr=0 st=0", clro1, st1);
    end
    pulse(0, 0, 0, 1, 0);   // recall with no laps stays IDLE
    total++;
    if (st1 !== 3'd0) begin
      bad++;
      $display("FAIL recall_empty got st=%0d exp st=0", st1);
    end
  endtask

  task automatic test_wrap();
    pulse(1, 0, 0, 0, 0);   // both RUN
    pulse(0, 0, 0, 0, 1);
    total++;
    if ({run1, st1} !== {1'b0, 3'd3}) begin
      bad++;
      $display("FAIL wrap_stop got run=%b st=%0d exp run=0 st=3", run1, st1);
    end
    total++;
    if ({run2, st2} !== {1'b1, 3'd1}) begin
      bad++;
      $display("FAIL wrap_through got run=%b st=%0d exp run=1 st=1", run2, st2);
    end
    pulse(1, 0, 0, 0, 0);   // dut1 RUN
    pulse(0, 1, 0, 0, 1);   // wrap beats lap
    total++;
    if ({st1, cnt1} !== {3'd3, 2'd0}) begin
      bad++;
      $display("FAIL wrap_over_lap got st=%0d cnt=%0d exp st=3 cnt=0", st1, cnt1);
    end
  endtask

  task automatic test_reset_mid();
    pulse(1, 0, 0, 0, 0);   // dut1 PAUSE -> RUN
    time_v = 16'h0777;
    pulse(0, 1, 0, 0, 0);
    total++;
    if ({st1, cnt1} !== {3'd2, 2'd1}) begin
      bad++;
      $display("FAIL mid_split got st=%0d cnt=%0d exp st=2 cnt=1", st1, cnt1);
    end
    time_v = 16'h0abc;
    #2;
    rst_ni = 1'b0;
    #1;
    total++;
    if ({run1, clro1, st1, cnt1, full1} !== {1'b0, 1'b0, 3'd0, 2'd0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset got=%h exp=%h", {run1, clro1, st1, cnt1, full1}, 8'h00);
    end
    total++;
    if (disp1 !== 16'h0abc) begin
      bad++;
      $display("FAIL async_reset_disp got=%h exp=%h", disp1, 16'h0abc);
    end
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    pulse(1, 0, 0, 0, 0);
    total++;
    if ({run1, clro1, st1} !== {1'b1, 1'b0, 3'd1}) begin
      bad++;
      $display("FAIL post_reset_run got run=%b clr=%b st=%0d exp run=1 clr=0 st=1", run1, clro1, st1);
    end
  endtask

  initial begin
    test_reset();
    test_start_stop();
    test_split_timing();
    test_lap_overflow();
    test_clear_priority();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
